// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS instruction-fetch slice.
package mips_pkg;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/mips_fetch_unit_if.sv
// Fetch-to-decode handshake bundle.
// A transfer happens on every rising edge where out_valid & out_ready are both 1.
// While out_valid=1 and out_ready=0, out_instr/out_pc hold steady and valid never drops.
interface mips_fetch_unit_if;
  import mips_pkg::*;

  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;

  modport master (output out_valid, output out_instr, output out_pc, input out_ready);
  modport slave  (input out_valid, input out_instr, input out_pc, output out_ready);
endinterface

// File: rtl/mips_fetch_buf.sv
// Small synchronous FIFO of {pc, instr} fetch entries with push/pop/flush.
module mips_fetch_buf
  import mips_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push_i,
  input  fetch_entry_t                  push_data_i,
  input  logic                          pop_i,
  input  logic                          flush_i,
  output logic [$clog2(DEPTH+1)-1:0]    count_o,
  output logic                          full_o,
  output fetch_entry_t                  head_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & (count_q != '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction-fetch initiator: PC register, fetch buffer, redirect/flush control.
// Optional macro MIPS_FETCH_ALIGN_CHECK_EN enables the sticky misaligned-redirect flag.
module mips_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int                BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  mips_fetch_unit_if.master  out_if,
  output logic               misalign_err
);
  logic [ADDR_W-1:0]              pc_q, pc_d;
  logic                           push, pop, full, err_q;
  logic [$clog2(BUF_DEPTH+1)-1:0] count;
  fetch_entry_t                   push_entry, head;

`ifdef MIPS_FETCH_ALIGN_CHECK_EN
  logic err_d;

  // Each redirect re-evaluates the flag: misaligned sets it, aligned clears it.
  always_comb begin
    err_d = err_q;
    if (redirect_valid) err_d = |redirect_target[1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end
`else
  assign err_q = 1'b0;
`endif

  assign push       = fetch_en & ~full & ~redirect_valid & ~err_q;
  assign pop        = out_if.out_valid & out_if.out_ready;
  assign push_entry = '{pc: pc_q, instr: imem_rdata};

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) pc_d = redirect_target & ~ADDR_W'(3);
    else if (push)      pc_d = pc_q + ADDR_W'(4);
  end

  always_ff @(posedge clk) begin
    if (reset) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

  mips_fetch_buf #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .flush_i     (redirect_valid),
    .count_o     (count),
    .full_o      (full),
    .head_o      (head)
  );

  assign imem_addr        = pc_q;
  assign out_if.out_valid = (count != '0);
  assign out_if.out_instr = head.instr;
  assign out_if.out_pc    = head.pc;
  assign misalign_err     = err_q;
endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed table-driven bench for mips_fetch_unit with a combinational memory model.
module tb_mips_fetch_unit;
  import mips_pkg::*;

  logic        clk, reset, fetch_en, redirect_valid, misalign_err;
  logic [31:0] imem_addr, imem_rdata, redirect_target;

  mips_fetch_unit_if out_if ();

  mips_fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .fetch_en        (fetch_en),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .out_if          (out_if.master),
    .misalign_err    (misalign_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return 32'h2000_0000 + (pc >> 2);
  endfunction

  assign imem_rdata = word_at(imem_addr);

  typedef struct {
    logic        fe;
    logic        rdy;
    logic        rv;
    logic [31:0] tgt;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic        exp_err;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs [NV];
  int   pass_cnt = 0;
  int   check_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic set_vec(input int i, input logic fe, input logic rdy, input logic rv,
                         input logic [31:0] tgt, input logic [31:0] addr, input logic v,
                         input logic [31:0] pc, input logic err);
    vecs[i] = '{fe: fe, rdy: rdy, rv: rv, tgt: tgt, exp_addr: addr,
                exp_valid: v, exp_pc: pc, exp_err: err};
  endtask

  task automatic drive(input logic rst, input logic fe, input logic rdy,
                       input logic rv, input logic [31:0] tgt);
    reset            = rst;
    fetch_en         = fe;
    out_if.out_ready = rdy;
    redirect_valid   = rv;
    redirect_target  = tgt;
  endtask

  task automatic check_state(input string tag, input logic [31:0] addr, input logic v,
                             input logic [31:0] pc, input logic [31:0] instr, input logic err);
    chk({tag, ".addr"},  imem_addr, addr);
    chk({tag, ".valid"}, 32'(out_if.out_valid), 32'(v));
    chk({tag, ".err"},   32'(misalign_err), 32'(err));
    if (v) begin
      chk({tag, ".pc"},    out_if.out_pc, pc);
      chk({tag, ".instr"}, out_if.out_instr, instr);
    end
  endtask

  initial begin
    // stream, backpressure, redirect-with-pop, fetch_en stall, PC wrap, misaligned redirect
    set_vec(0,  1, 1, 0, 0, 32'h0,  0, 0, 0);
    set_vec(1,  1, 0, 0, 0, 32'h4,  1, 32'h0, 0);
    set_vec(2,  1, 0, 0, 0, 32'h8,  1, 32'h0, 0);
    set_vec(3,  1, 0, 0, 0, 32'h8,  1, 32'h0, 0);
    set_vec(4,  1, 0, 0, 0, 32'h8,  1, 32'h0, 0);
    set_vec(5,  1, 0, 0, 0, 32'h8,  1, 32'h0, 0);
    set_vec(6,  1, 1, 0, 0, 32'h8,  1, 32'h0, 0);
    set_vec(7,  1, 1, 0, 0, 32'h8,  1, 32'h4, 0);
    set_vec(8,  1, 0, 0, 0, 32'hC,  1, 32'h8, 0);
    set_vec(9,  1, 1, 1, 32'h40, 32'h10, 1, 32'h8, 0);
    set_vec(10, 1, 1, 0, 0, 32'h40, 0, 0, 0);
    set_vec(11, 1, 1, 0, 0, 32'h44, 1, 32'h40, 0);
    set_vec(12, 0, 1, 0, 0, 32'h48, 1, 32'h44, 0);
    set_vec(13, 0, 1, 0, 0, 32'h48, 0, 0, 0);
    set_vec(14, 0, 1, 0, 0, 32'h48, 0, 0, 0);
    set_vec(15, 1, 1, 0, 0, 32'h48, 0, 0, 0);
    set_vec(16, 1, 1, 1, 32'hFFFF_FFF8, 32'h4C, 1, 32'h48, 0);
    set_vec(17, 1, 1, 0, 0, 32'hFFFF_FFF8, 0, 0, 0);
    set_vec(18, 1, 1, 0, 0, 32'hFFFF_FFFC, 1, 32'hFFFF_FFF8, 0);
    set_vec(19, 1, 1, 0, 0, 32'h0,  1, 32'hFFFF_FFFC, 0);
    set_vec(20, 1, 1, 1, 32'h42, 32'h4, 1, 32'h0, 0);
`ifdef MIPS_FETCH_ALIGN_CHECK_EN
    set_vec(21, 1, 1, 0, 0, 32'h40, 0, 0, 1);
    set_vec(22, 1, 1, 0, 0, 32'h40, 0, 0, 1);
    set_vec(23, 1, 1, 1, 32'h80, 32'h40, 0, 0, 1);
`else
    set_vec(21, 1, 1, 0, 0, 32'h40, 0, 0, 0);
    set_vec(22, 1, 1, 0, 0, 32'h44, 1, 32'h40, 0);
    set_vec(23, 1, 1, 1, 32'h80, 32'h48, 1, 32'h44, 0);
`endif
    set_vec(24, 1, 1, 0, 0, 32'h80, 0, 0, 0);
    set_vec(25, 1, 1, 0, 0, 32'h84, 1, 32'h80, 0);

    drive(1, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 chk("reset.addr",  imem_addr, 32'h0);
    chk("reset.valid", 32'(out_if.out_valid), 32'h0);
    chk("reset.pc",    out_if.out_pc, 32'h0);
    chk("reset.instr", out_if.out_instr, 32'h0);
    chk("reset.err",   32'(misalign_err), 32'h0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(0, vecs[i].fe, vecs[i].rdy, vecs[i].rv, vecs[i].tgt);
      #1 check_state($sformatf("v%0d", i), vecs[i].exp_addr, vecs[i].exp_valid,
                     vecs[i].exp_pc, word_at(vecs[i].exp_pc), vecs[i].exp_err);
    end

    // Reset mid-stream must win over a simultaneous redirect, push and pop.
    @(negedge clk);
    drive(1, 1, 1, 1, 32'h100);
    @(negedge clk);
    drive(0, 1, 1, 0, 0);
    #1 chk("midrst.addr",  imem_addr, 32'h0);
    chk("midrst.valid", 32'(out_if.out_valid), 32'h0);
    chk("midrst.pc",    out_if.out_pc, 32'h0);
    chk("midrst.instr", out_if.out_instr, 32'h0);
    chk("midrst.err",   32'(misalign_err), 32'h0);
    @(negedge clk);
    #1 check_state("post_rst", 32'h4, 1, 32'h0, 32'h2000_0000, 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
